kuart_cmd_injector: RTL and testbench
=====================================

// Module: kuart_cmd_injector
// PURPOSE
//  Sim-support stimulus block that drives the kernel console UART into the CPU. When armed, it waits for a
//  prompt byte from the CPU, then sends a fixed command string one byte per valid/ready handshake. An
//  inter-byte gap separates bytes. Completion is reported on done/timeout, as a companion to the end-of-sim finisher.
// PARAMETERS
//  CMD_LEN         4           number of command bytes, 1..255
//  CMD             "ram\n"     packed string, width 8*CMD_LEN; byte i = CMD[8*(CMD_LEN-1-i) +: 8] (literal order)
//  PROMPT          8'h3e       byte from CPU ('>') that releases transmission
//  GAP_CYCLES      16          idle cycles after each accepted byte, 0..65535
//  TIMEOUT_CYCLES  1_000_000   max cycles in any wait state before failing, 32-bit
// PORTS
//  clk                 in   1   sole clock
//  reset               in   1   synchronous, active-high
//  start               in   1   level; rising edge arms the block while in IDLE
//  kuart_from_cpu      in   8   byte emitted by CPU console
//  kuart_from_cpu_valid in  1   one-cycle strobe qualifying kuart_from_cpu
//  kuart_to_cpu        out  8   byte presented to CPU
//  kuart_to_cpu_valid  out  1   byte valid; held until ready
//  kuart_to_cpu_ready  in   1   CPU accepts byte when valid&ready at posedge clk
//  busy                out  1   high in any state other than IDLE/DONE/FAIL
//  done                out  1   sticky; command fully sent (and echoed, if ECHO_CHECK_EN)
//  timeout             out  1   sticky; a wait exceeded TIMEOUT_CYCLES
//  echo_err            out  1   sticky; echoed byte mismatch (ECHO_CHECK_EN only, else tied 0)
//  chars_sent          out  8   count of bytes accepted by CPU
// BEHAVIOUR
//  Reset: state=IDLE; kuart_to_cpu=8'h00, valid=0, busy=0, done=0, timeout=0, echo_err=0, chars_sent=0.
//  Reset mid-operation aborts instantly; a pending valid drops the cycle after reset is sampled.
//  States: IDLE -> WAIT_PROMPT -> SEND -> GAP -> (SEND | WAIT_ECHO | DONE); any wait -> FAIL.
//  IDLE: start rising edge (start & !start_d) -> WAIT_PROMPT, clear timeout counter. start held high does not re-arm.
//  WAIT_PROMPT: kuart_from_cpu_valid & kuart_from_cpu==PROMPT -> SEND next cycle. Other bytes ignored.
//  SEND: valid=1, data=byte[idx]; data/valid stable until ready. On valid&ready: idx++, chars_sent++,
//   valid=0 next cycle, -> GAP. Ready high before valid has no effect. Ready asserted in the same cycle as
//   valid rising completes the transfer (latency 1 cycle min per byte).
//  GAP: counts GAP_CYCLES cycles (0 => leave immediately next cycle). Then: idx<CMD_LEN -> SEND;
//   else -> WAIT_ECHO if ECHO_CHECK_EN, else DONE.
//  WAIT_PROMPT/SEND/WAIT_ECHO: 32-bit counter increments each cycle, resets on state entry; reaching
//   TIMEOUT_CYCLES -> FAIL, timeout=1, valid=0. Counter saturates; no wrap.
//  DONE: done=1, busy=0; holds until reset. FAIL: timeout and/or echo_err held, done=0, until reset.
//  chars_sent saturates at 255. Simultaneous prompt+timeout in same cycle: prompt wins.
// CONFIGURATION
//  ECHO_CHECK_EN defined: each from_cpu byte arriving after WAIT_PROMPT exit is compared in order with
//   byte[echo_idx]; mismatch -> echo_err=1, FAIL. WAIT_ECHO exits to DONE when echo_idx==CMD_LEN.
//   Echoes may arrive during SEND/GAP; they are counted then.
//  ECHO_CHECK_EN undefined: from_cpu ignored after prompt; WAIT_ECHO unreachable; echo_err constant 0.
// TESTING
//  1 Reset, start pulse, send '>' with ready tied 1 -> bytes 72,61,6d,0a in order, each separated by 16
//    idle cycles; done=1; chars_sent=4.
//  2 Ready held 0 for 50 cycles during byte 2 -> kuart_to_cpu=8'h61 and valid stable all 50 cycles;
//    transfer completes on first ready cycle.
//  3 TIMEOUT_CYCLES=100, no prompt -> timeout=1 at cycle 100 after arming, valid never asserted, done=0.
//  4 ECHO_CHECK_EN, CPU echoes 72,61,78,0a -> echo_err=1 on third echo, FAIL, done=0.
//  5 Reset asserted while byte 1 valid & ready low -> all outputs at reset values next cycle; new start
//    + prompt resends from byte 0.
//  6 start held high through DONE -> no second transmission; chars_sent stays 4.

Source files
------------

// File: rtl/kuart_cmd_injector.sv
// kuart_cmd_injector
// ------------------
// Simulation-support stimulus block for the kernel console UART. Once armed
// by a rising edge on `start`, it waits for the CPU to print the prompt byte.
// It then sends the command string CMD one byte at a time. After each accepted
// byte it waits GAP_CYCLES idle cycles. It reports completion on `done` and a
// stalled wait on `timeout`.
//
// Optional build macro: ECHO_CHECK_EN
//   Defined   - bytes the CPU emits after the prompt are compared in order
//               against the command. A mismatch sets echo_err and the block
//               ends in FAIL. After the last byte is sent, the block waits in
//               WAIT_ECHO until every byte has been echoed.
//   Undefined - bytes from the CPU are ignored after the prompt, and
//               echo_err is tied to 0.
//
// Ports
//   clk                  in   1  sole clock
//   reset                in   1  synchronous, active-high
//   start                in   1  level; a rising edge arms the block in IDLE
//   kuart_from_cpu       in   8  console byte from the CPU
//   kuart_from_cpu_valid in   1  one-cycle strobe qualifying kuart_from_cpu
//   kuart_to_cpu         out  8  command byte presented to the CPU
//   kuart_to_cpu_valid   out  1  byte valid, held until accepted
//   kuart_to_cpu_ready   in   1  CPU acceptance
//   busy                 out  1  high outside IDLE/DONE/FAIL
//   done                 out  1  sticky, command fully sent (and echoed)
//   timeout              out  1  sticky, a wait state exceeded TIMEOUT_CYCLES
//   echo_err             out  1  sticky, echoed byte mismatch
//   chars_sent           out  8  bytes accepted by the CPU, saturating at 255
//
// Handshake: a byte transfers on a rising clock edge where valid and ready
// are both high. While valid is high without ready, the data and valid
// outputs hold their values. Ready has no effect while valid is low.

module kuart_cmd_injector #(
    parameter int unsigned          CMD_LEN        = 4,
    parameter logic [8*CMD_LEN-1:0] CMD            = "ram\n",
    parameter logic [7:0]           PROMPT         = 8'h3e,
    parameter int unsigned          GAP_CYCLES     = 16,
    parameter logic [31:0]          TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] kuart_from_cpu,
    input  logic       kuart_from_cpu_valid,
    output logic [7:0] kuart_to_cpu,
    output logic       kuart_to_cpu_valid,
    input  logic       kuart_to_cpu_ready,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       echo_err,
    output logic [7:0] chars_sent
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_PROMPT = 3'd1;
    localparam logic [2:0] S_SEND        = 3'd2;
    localparam logic [2:0] S_GAP         = 3'd3;
    localparam logic [2:0] S_WAIT_ECHO   = 3'd4;
    localparam logic [2:0] S_DONE        = 3'd5;
    localparam logic [2:0] S_FAIL        = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        start_d_q;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [31:0] tcnt_q, tcnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  chars_q, chars_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic [31:0] tcnt_inc;
    logic        timed_out;
    logic        handshake;
    logic        gap_over;
    logic        more_bytes;
    logic        echo_mismatch;

    // Command byte i, first character of the string literal first.
    function automatic logic [7:0] cmd_byte(input logic [7:0] i);
        cmd_byte = 8'h00;
        for (int k = 0; k < int'(CMD_LEN); k++) begin
            if (i == 8'(k)) begin
                cmd_byte = CMD[8*(int'(CMD_LEN)-1-k) +: 8];
            end
        end
    endfunction

    // Wait counter saturates instead of wrapping.
    assign tcnt_inc   = (tcnt_q == 32'hffff_ffff) ? tcnt_q : tcnt_q + 32'd1;
    assign timed_out  = (tcnt_inc >= TIMEOUT_CYCLES);
    assign handshake  = valid_q & kuart_to_cpu_ready;
    // GAP_CYCLES == 0 still spends one cycle in GAP.
    assign gap_over   = (GAP_CYCLES == 0) ||
                        (({1'b0, gap_cnt_q} + 17'd1) >= 17'(GAP_CYCLES));
    assign more_bytes = ({1'b0, idx_q} < 9'(CMD_LEN));

`ifdef ECHO_CHECK_EN
    logic [7:0] echo_idx_q, echo_idx_d;
    logic       echo_err_q, echo_err_d;
    logic       echo_complete;

    // Echo tracking is active from prompt acceptance until the block
    // finishes, so echoes arriving during SEND/GAP are counted.
    always_comb begin
        echo_idx_d    = echo_idx_q;
        echo_mismatch = 1'b0;
        if (state_q == S_IDLE) begin
            echo_idx_d = 8'd0;
        end else if ((state_q == S_SEND || state_q == S_GAP ||
                      state_q == S_WAIT_ECHO) && kuart_from_cpu_valid &&
                     ({1'b0, echo_idx_q} < 9'(CMD_LEN))) begin
            if (kuart_from_cpu == cmd_byte(echo_idx_q)) begin
                echo_idx_d = echo_idx_q + 8'd1;
            end else begin
                echo_mismatch = 1'b1;
            end
        end
        echo_complete = ({1'b0, echo_idx_d} == 9'(CMD_LEN));
        echo_err_d    = echo_err_q | echo_mismatch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            echo_idx_q <= 8'd0;
            echo_err_q <= 1'b0;
        end else begin
            echo_idx_q <= echo_idx_d;
            echo_err_q <= echo_err_d;
        end
    end

    assign echo_err = echo_err_q;
`else
    assign echo_mismatch = 1'b0;
    assign echo_err      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        data_d    = data_q;
        valid_d   = valid_q;
        tcnt_d    = tcnt_inc;
        gap_cnt_d = gap_cnt_q;
        chars_d   = chars_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        if (handshake && chars_q != 8'hff) begin
            chars_d = chars_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                tcnt_d = 32'd0;
                idx_d  = 8'd0;
                if (start && !start_d_q) begin
                    state_d = S_WAIT_PROMPT;
                end
            end
            S_WAIT_PROMPT: begin
                // The prompt takes priority over a timeout in the same cycle.
                if (kuart_from_cpu_valid && kuart_from_cpu == PROMPT) begin
                    state_d = S_SEND;
                    tcnt_d  = 32'd0;
                    valid_d = 1'b1;
                    data_d  = cmd_byte(idx_q);
                end else if (timed_out) begin
                    state_d   = S_FAIL;
                    timeout_d = 1'b1;
                end
            end
            S_SEND: begin
                if (echo_mismatch) begin
                    state_d = S_FAIL;
                    valid_d = 1'b0;
                end else if (handshake) begin
                    state_d   = S_GAP;
                    idx_d     = idx_q + 8'd1;
                    valid_d   = 1'b0;
                    gap_cnt_d = 16'd0;
                end else if (timed_out) begin
                    state_d   = S_FAIL;
                    timeout_d = 1'b1;
                    valid_d   = 1'b0;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (echo_mismatch) begin
                    state_d = S_FAIL;
                end else if (gap_over) begin
                    if (more_bytes) begin
                        state_d = S_SEND;
                        tcnt_d  = 32'd0;
                        valid_d = 1'b1;
                        data_d  = cmd_byte(idx_q);
                    end else begin
`ifdef ECHO_CHECK_EN
                        state_d = S_WAIT_ECHO;
                        tcnt_d  = 32'd0;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
            S_WAIT_ECHO: begin
`ifdef ECHO_CHECK_EN
                if (echo_mismatch) begin
                    state_d = S_FAIL;
                end else if (echo_complete) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (timed_out) begin
                    state_d   = S_FAIL;
                    timeout_d = 1'b1;
                end
`else
                // Not reachable without echo checking.
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_FAIL: begin
                state_d = S_FAIL;
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_d_q <= 1'b0;
            idx_q     <= 8'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            tcnt_q    <= 32'd0;
            gap_cnt_q <= 16'd0;
            chars_q   <= 8'd0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_d_q <= start;
            idx_q     <= idx_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            tcnt_q    <= tcnt_d;
            gap_cnt_q <= gap_cnt_d;
            chars_q   <= chars_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign kuart_to_cpu       = data_q;
    assign kuart_to_cpu_valid = valid_q;
    assign busy               = (state_q != S_IDLE) && (state_q != S_DONE) &&
                                (state_q != S_FAIL);
    assign done               = done_q;
    assign timeout            = timeout_q;
    assign chars_sent         = chars_q;

endmodule

// File: tb/tb_kuart_cmd_injector.sv
// Testbench for kuart_cmd_injector. The design uses "ram\n", PROMPT '>',
// GAP_CYCLES 16 and TIMEOUT_CYCLES 100. Inputs are driven and outputs are
// sampled on the falling clock edge.

module tb_kuart_cmd_injector;

    localparam int         N_BYTES  = 4;
    localparam int         GAP      = 16;
    localparam int         TMO      = 100;
    localparam logic [7:0] PROMPT_B = 8'h3e;
    localparam int         GAP_EXP  = (GAP == 0) ? 1 : GAP;
`ifdef ECHO_CHECK_EN
    localparam int         DONE_LAT = GAP_EXP + 1;
`else
    localparam int         DONE_LAT = GAP_EXP;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] from_cpu;
    logic       from_valid;
    logic [7:0] to_cpu;
    logic       to_valid;
    logic       to_ready;
    logic       busy;
    logic       done;
    logic       timeout;
    logic       echo_err;
    logic [7:0] chars_sent;

    kuart_cmd_injector #(
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .kuart_from_cpu      (from_cpu),
        .kuart_from_cpu_valid(from_valid),
        .kuart_to_cpu        (to_cpu),
        .kuart_to_cpu_valid  (to_valid),
        .kuart_to_cpu_ready  (to_ready),
        .busy                (busy),
        .done                (done),
        .timeout             (timeout),
        .echo_err            (echo_err),
        .chars_sent          (chars_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] cmd_bytes [N_BYTES];

    typedef struct {
        int            junk;
        bit [3:0][7:0] stall;
        int            bad_echo;
        bit            hold_start;
        bit            exp_done;
        bit            exp_timeout;
        bit            exp_echo_err;
        logic [7:0]    exp_chars;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int junk, input bit [7:0] s0, input bit [7:0] s1,
                                input bit [7:0] s2, input bit [7:0] s3, input int bad,
                                input bit hold, input bit d, input bit t, input bit e,
                                input logic [7:0] c);
        vec_t v;
        v.junk         = junk;
        v.stall        = {s3, s2, s1, s0};
        v.bad_echo     = bad;
        v.hold_start   = hold;
        v.exp_done     = d;
        v.exp_timeout  = t;
        v.exp_echo_err = e;
        v.exp_chars    = c;
        return v;
    endfunction

    function automatic logic [7:0] rand_nonprompt();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == PROMPT_B) b = 8'h3f;
        return b;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_to_cpu"},   32'(to_cpu),     32'h0);
        check({tag, "_valid"},    32'(to_valid),   32'h0);
        check({tag, "_busy"},     32'(busy),       32'h0);
        check({tag, "_done"},     32'(done),       32'h0);
        check({tag, "_timeout"},  32'(timeout),    32'h0);
        check({tag, "_echo_err"}, 32'(echo_err),   32'h0);
        check({tag, "_chars"},    32'(chars_sent), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        reset      = 1'b1;
        start      = 1'b0;
        from_valid = 1'b0;
        from_cpu   = 8'h00;
        to_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals(tag);
        reset = 1'b0;
    endtask

    // Arms the block, feeds junk then the prompt, and plays the CPU side:
    // stalls ready per byte, echoes accepted bytes, and checks each byte,
    // the idle gap, the latencies and the final flags against the model.
    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] exp_q [$];
        logic [7:0] echo_q [$];
        int model_chars = 0;
        int byte_i      = 0;
        int waited      = 0;
        int low_cnt     = 0;
        bit in_gap      = 1'b0;
        bit fin         = 1'b0;
        for (int i = 0; i < N_BYTES; i++) exp_q.push_back(cmd_bytes[i]);

        start = 1'b1;
        @(negedge clk);
        if (!v.hold_start) start = 1'b0;
        check({tag, "_arm_busy"}, 32'(busy), 32'h1);
        for (int j = 0; j < v.junk; j++) begin
            check({tag, "_junk_valid"}, 32'(to_valid), 32'h0);
            from_cpu   = rand_nonprompt();
            from_valid = 1'b1;
            @(negedge clk);
        end
        check({tag, "_pre_prompt_valid"}, 32'(to_valid), 32'h0);
        from_cpu   = PROMPT_B;
        from_valid = 1'b1;
        @(negedge clk);
        from_valid = 1'b0;
        check({tag, "_prompt_latency"}, 32'(to_valid), 32'h1);

        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            check({tag, "_chars"}, 32'(chars_sent), 32'(model_chars));
            if (done || timeout || echo_err) begin
                fin = 1'b1;
                if (done) begin
                    check({tag, "_done_latency"}, 32'(low_cnt), 32'(DONE_LAT));
                    check({tag, "_all_sent"}, 32'(exp_q.size()), 32'h0);
                end
                if (timeout && !in_gap && byte_i < N_BYTES) begin
                    check({tag, "_send_timeout_latency"}, 32'(waited), 32'(TMO));
                end
            end else begin
                check({tag, "_busy"}, 32'(busy), 32'h1);
                if (echo_q.size() > 0) begin
                    from_cpu   = echo_q.pop_front();
                    from_valid = 1'b1;
                end else begin
                    from_valid = 1'b0;
                end
                if (to_valid) begin
                    if (in_gap) begin
                        check({tag, "_gap_len"}, 32'(low_cnt), 32'(GAP_EXP));
                        in_gap = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_byte"}, 32'(to_valid), 32'h0);
                        to_ready = 1'b1;
                    end else begin
                        check({tag, "_data"}, 32'(to_cpu), 32'(exp_q[0]));
                        if (waited >= int'(v.stall[byte_i])) begin
                            to_ready = 1'b1;
                            echo_q.push_back((byte_i == v.bad_echo) ? 8'h78 : exp_q[0]);
                            void'(exp_q.pop_front());
                            model_chars++;
                            byte_i++;
                            waited  = 0;
                            in_gap  = 1'b1;
                            low_cnt = 0;
                        end else begin
                            to_ready = 1'b0;
                            waited++;
                        end
                    end
                end else begin
                    to_ready = 1'($urandom_range(0, 1));
                    if (in_gap) low_cnt++;
                end
                @(negedge clk);
            end
        end
        from_valid = 1'b0;
        to_ready   = 1'b0;
        check({tag, "_finished"}, 32'(fin), 32'h1);
        check({tag, "_done"},     32'(done),       32'(v.exp_done));
        check({tag, "_timeout"},  32'(timeout),    32'(v.exp_timeout));
        check({tag, "_echo_err"}, 32'(echo_err),   32'(v.exp_echo_err));
        check({tag, "_chars_end"}, 32'(chars_sent), 32'(v.exp_chars));
        check({tag, "_idle_busy"}, 32'(busy),      32'h0);
        check({tag, "_idle_valid"}, 32'(to_valid), 32'h0);

        // Terminal states hold: no resend on prompts, ready or a held start.
        for (int k = 0; k < 30; k++) begin
            from_cpu   = ($urandom_range(0, 1) == 1) ? PROMPT_B : rand_nonprompt();
            from_valid = 1'($urandom_range(0, 1));
            to_ready   = 1'b1;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(to_valid),   32'h0);
            check({tag, "_hold_chars"}, 32'(chars_sent), 32'(v.exp_chars));
            check({tag, "_hold_done"},  32'(done),       32'(v.exp_done));
        end
        from_valid = 1'b0;
        to_ready   = 1'b0;
        start      = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        from_cpu   = 8'h00;
        from_valid = 1'b0;
        to_ready   = 1'b0;
        cmd_bytes  = '{8'h72, 8'h61, 8'h6d, 8'h0a};

        vecs[0] = mk(0, 0, 0, 0, 0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        vecs[1] = mk(2, 0, 50, 0, 0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        vecs[2] = mk(3, 3, 1, 2, 5, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        vecs[3] = mk(1, 0, 0, 150, 0, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
`ifdef ECHO_CHECK_EN
        vecs[4] = mk(0, 0, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
`else
        vecs[4] = mk(0, 0, 0, 0, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
`endif
        vecs[5] = mk(4, 0, 0, 0, 97, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);

        @(negedge clk);
        do_reset("reset");

        for (int i = 0; i < 6; i++) begin
            do_reset($sformatf("v%0d_rst", i));
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // No prompt: timeout exactly TMO cycles after arming, never valid.
        do_reset("t3_rst");
        start = 1'b1;
        for (int i = 0; i < TMO + 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("t3_timeout", 32'(timeout),  32'(i >= TMO));
            check("t3_valid",   32'(to_valid), 32'h0);
            check("t3_busy",    32'(busy),     32'(i < TMO));
            from_cpu   = rand_nonprompt();
            from_valid = 1'($urandom_range(0, 1));
        end
        from_valid = 1'b0;
        check("t3_done", 32'(done), 32'h0);

        // Reset while byte 0 is pending with ready low, then a clean resend.
        do_reset("t5_rst");
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        from_cpu   = PROMPT_B;
        from_valid = 1'b1;
        @(negedge clk);
        from_valid = 1'b0;
        check("t5_pending_valid", 32'(to_valid), 32'h1);
        check("t5_pending_data",  32'(to_cpu),   32'h72);
        @(negedge clk);
        check("t5_still_valid", 32'(to_valid), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t5_abort");
        reset = 1'b0;
        run_vec(vecs[2], "t5_resend");

        // Randomized transactions against the model.
        for (int r = 0; r < 8; r++) begin
            vec_t v;
            v = mk($urandom_range(0, 5),
                   8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                   8'($urandom_range(0, 6)), 8'($urandom_range(0, 6)),
                   -1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 8'd4);
            do_reset($sformatf("r%0d_rst", r));
            run_vec(v, $sformatf("r%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
